inst_fetch_port: RTL

Instruction-memory side of the fetch interface. It accepts the fetch stage's chip-enable and address, and serves each instruction from a one-entry tagged buffer or from a variable-latency instruction bus. While a fetch is outstanding it raises a stall request to the pipeline controller. It also handles flush cancellation and bus timeout.

---
 rtl/inst_fetch_port.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_port.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_port
// Description : Instruction-memory side of the fetch interface. Serves each
//               aligned fetch either from a one-entry tagged buffer (hit, zero
//               stall) or by issuing a single read on a variable-latency
//               instruction bus (miss, stall until the buffer is refilled).
//               Handles flush cancellation of an outstanding read and a bus
//               timeout that fills the buffer with an error-tagged NOP.
//
// Ports       : clk, rst      - clock, synchronous active-high reset
//               ice, iaddr    - fetch enable and byte address from fetch stage
//               flush         - exception flush, cancels outstanding fetch
//               inst          - instruction for iaddr (valid when !stallreq_if)
//               stallreq_if   - fetch not yet satisfied, stall the pipeline
//               ibus_err      - current inst comes from a timed-out fetch
//               bus_req       - registered bus read request
//               bus_addr      - registered word-aligned bus read address
//               bus_gnt       - bus accepted the request this cycle
//               bus_rvalid    - read data valid
//               bus_rdata     - read data
//
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_port #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ice,
    input  logic [31:0] iaddr,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stallreq_if,
    output logic        ibus_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // The counter only has to reach TIMEOUT-1 (the last WAIT cycle before
    // giving up), so it is sized for values 0..TIMEOUT-1.
    localparam int unsigned        c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_DISCARD = 2'd3;

    // ------------------------------------------------------------------------
    // State and buffer registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [29:0]        r_req_addr;
    logic               r_cancel;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bus_req;
    logic [31:0]        r_bus_addr;
    logic               r_buf_valid;
    logic               r_buf_err;
    logic [29:0]        r_buf_addr;
    logic [31:0]        r_buf_data;

    // Next-state values
    logic [1:0]         w_state;
    logic [29:0]        w_req_addr;
    logic               w_cancel;
    logic [c_CNT_W-1:0] w_cnt;
    logic               w_bus_req;
    logic [31:0]        w_bus_addr;
    logic               w_buf_valid;
    logic               w_buf_err;
    logic [29:0]        w_buf_addr;
    logic [31:0]        w_buf_data;

    logic               w_aligned;
    logic               w_hit;
    logic               w_miss;
    logic               w_timeout;
    logic               w_drop;

    // ------------------------------------------------------------------------
    // Combinational fetch-side outputs
    // ------------------------------------------------------------------------
    assign w_aligned = (iaddr[1:0] == 2'b00);

    // The hit is qualified with ice and alignment so that a disabled or
    // misaligned fetch whose word address happens to match the buffer still
    // returns NOP_WORD and never reports a bus error.
    assign w_hit  = ice && w_aligned && r_buf_valid && (r_buf_addr == iaddr[31:2]);
    assign w_miss = ice && w_aligned && !flush && !w_hit;

    assign stallreq_if = w_miss;
    assign inst        = w_hit ? r_buf_data : NOP_WORD;
    assign ibus_err    = w_hit && r_buf_err;

    assign bus_req  = r_bus_req;
    assign bus_addr = r_bus_addr;

    // Timeout fires in the WAIT cycle whose count is TIMEOUT-1, i.e. after
    // exactly TIMEOUT WAIT cycles without read data.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    // A response granted in REQ is dropped if a flush arrived at any point
    // while the request was pending, including the grant cycle itself.
    assign w_drop = r_cancel || flush;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_req_addr  = r_req_addr;
        w_cancel    = r_cancel;
        w_cnt       = r_cnt;
        w_bus_req   = r_bus_req;
        w_bus_addr  = r_bus_addr;
        w_buf_valid = r_buf_valid;
        w_buf_err   = r_buf_err;
        w_buf_addr  = r_buf_addr;
        w_buf_data  = r_buf_data;

        case (r_state)
            c_ST_IDLE: begin
                // Stray responses (e.g. after a mid-transaction reset) are
                // ignored here simply by never looking at bus_rvalid.
                if (flush) begin
                    w_buf_valid = 1'b0;
                end else if (w_miss) begin
                    w_req_addr = iaddr[31:2];
                    w_bus_req  = 1'b1;
                    w_bus_addr = {iaddr[31:2], 2'b00};
                    w_cancel   = 1'b0;
                    w_state    = c_ST_REQ;
                end
            end

            c_ST_REQ: begin
                // The request is never withdrawn: bus_req/bus_addr hold until
                // the grant, even across a flush.
                if (flush) begin
                    w_cancel = 1'b1;
                end
                if (bus_gnt) begin
                    w_bus_req = 1'b0;
                    w_cnt     = '0;
                    if (bus_rvalid) begin
                        if (!w_drop) begin
                            w_buf_addr  = r_req_addr;
                            w_buf_data  = bus_rdata;
                            w_buf_err   = 1'b0;
                            w_buf_valid = 1'b1;
                        end
                        w_state = c_ST_IDLE;
                    end else if (w_drop) begin
                        w_state = c_ST_DISCARD;
                    end else begin
                        w_state = c_ST_WAIT;
                    end
                end
            end

            c_ST_WAIT: begin
                w_cnt = r_cnt + c_CNT_W'(1);
                if (flush) begin
                    w_buf_valid = 1'b0;
                    w_state     = bus_rvalid ? c_ST_IDLE : c_ST_DISCARD;
                end else if (bus_rvalid) begin
                    // Read data beats a coincident timeout.
                    w_buf_addr  = r_req_addr;
                    w_buf_data  = bus_rdata;
                    w_buf_err   = 1'b0;
                    w_buf_valid = 1'b1;
                    w_state     = c_ST_IDLE;
                end else if (w_timeout) begin
                    // Satisfy the fetch with an error-tagged NOP, but the bus
                    // still owes a response which must be swallowed before a
                    // new request may go out.
                    w_buf_addr  = r_req_addr;
                    w_buf_data  = NOP_WORD;
                    w_buf_err   = 1'b1;
                    w_buf_valid = 1'b1;
                    w_state     = c_ST_DISCARD;
                end
            end

            c_ST_DISCARD: begin
                if (bus_rvalid) begin
                    w_state = c_ST_IDLE;
                end
            end

            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_req_addr  <= '0;
            r_cancel    <= 1'b0;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_buf_valid <= 1'b0;
            r_buf_err   <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            r_state     <= w_state;
            r_req_addr  <= w_req_addr;
            r_cancel    <= w_cancel;
            r_cnt       <= w_cnt;
            r_bus_req   <= w_bus_req;
            r_bus_addr  <= w_bus_addr;
            r_buf_valid <= w_buf_valid;
            r_buf_err   <= w_buf_err;
            r_buf_addr  <= w_buf_addr;
            r_buf_data  <= w_buf_data;
        end
    end

endmodule
`default_nettype wire
